fl_word_reader: RTL and testbench
=================================

FL_WORD_READER -- requirements
Module: fl_word_reader

Interface
REQ-001 Parameter: ACCESS_CYCLES, default 5, iclk cycles from address/OE valid to byte sample; legal 1..15.
REQ-002 iclk  in  1  clock; all logic on rising edge.
REQ-003 ireset  in  1  reset, synchronous, active-high.
REQ-004 iaddr  in  23  byte address of requested word, bit 0 ignored (word aligned).
REQ-005 ireq  in  1  toggle request; pending when ireq != oack.
REQ-006 oack  out  1  toggle acknowledge; oack == ireq means odata valid.
REQ-007 odata  out  16  assembled flash word.
REQ-008 ofl_addr  out  23  flash byte address.
REQ-009 ifl_dq  in  8  flash data bus, 8-bit mode, read only.
REQ-010 ofl_ce_n, ofl_oe_n, ofl_we_n, ofl_rst_n, ofl_wp_n  out  1 each  flash strobes, active-low.

Function
REQ-011 States: IDLE, READ_LO, READ_HI; any other encoding returns to IDLE next edge.
REQ-012 IDLE, pending request at edge N: latch iaddr[22:1]; drive ofl_addr={addr[22:1],0}; ce_n=oe_n=0; load counter=ACCESS_CYCLES-1; go READ_LO.
REQ-013 READ_LO, counter!=0: decrement; address and strobes held.
REQ-014 READ_LO, counter==0: capture ifl_dq as byte0; ofl_addr={addr[22:1],1}; reload counter; go READ_HI; ce_n/oe_n stay low.
REQ-015 READ_HI, counter==0: capture byte1; update odata; toggle oack; ce_n=oe_n=1; go IDLE, all in the same edge.
REQ-016 Latency: oack toggles exactly 2*ACCESS_CYCLES edges after the detect edge N (10 for default).
REQ-017 odata changes only on the acknowledge edge and holds until the next acknowledge.
REQ-018 ireq/iaddr changes outside IDLE are ignored; pending status is evaluated only in IDLE.
REQ-019 Pending request present on the acknowledge edge is not serviced; after toggle ireq==oack unless ireq toggled again, then serviced from IDLE next edge.
REQ-020 Back-to-back requests: minimum one IDLE cycle between acknowledge and next detect.
REQ-021 ofl_we_n=1 and ofl_wp_n=1 constant; no write/erase commands ever issued.
REQ-022 ofl_addr holds last value in IDLE.

Reset
REQ-023 During ireset: state=IDLE, oack=0, odata=0, ofl_addr=0, ce_n=oe_n=1, ofl_rst_n=0, counter=0.
REQ-024 First edge with ireset low: ofl_rst_n=1; requests accepted from the following edge.
REQ-025 Reset mid-transfer aborts without acknowledge; strobes deasserted on that edge.

Configuration
REQ-026 Macro FL_BYTESWAP_EN defined: odata={byte0,byte1} (big-endian, even address to [15:8]).
REQ-027 Macro FL_BYTESWAP_EN undefined: odata={byte1,byte0} (even address to [7:0]).

Structure
REQ-028 Package fl_pkg holds state encoding, FL_ADDR_W=23, FL_DQ_W=8, ACCESS_CYCLES default.
REQ-029 Single module; no sub-module; counter width 4 bits.

Verification
REQ-030 Flash model: byte[a]=a[7:0]^8'h5A; ireq 0->1, iaddr=0x000100, default params, macro off -> oack=1 exactly 10 edges later, odata=0x5B5A.
REQ-031 Same stimulus, FL_BYTESWAP_EN on -> odata=0x5A5B; ofl_addr 0x000100 then 0x000101.
REQ-032 ireq toggled at edge 3 of a transfer, iaddr changed to 0x7FFFFE -> first acknowledge returns old data; second acknowledge follows one IDLE cycle later with byte[0x7FFFFE]/byte[0x7FFFFF].
REQ-033 ireset pulsed at edge 6 of a transfer -> oack=0, odata=0, ce_n=oe_n=1, ofl_rst_n=0; no toggle afterwards until new request.
REQ-034 ACCESS_CYCLES=1 -> acknowledge 2 edges after detect; ACCESS_CYCLES=15 -> 30 edges; ofl_we_n=1 throughout all tests.
REQ-035 Streaming 1000 sequential word requests, address 0 step 2 -> every odata matches model, no missed or duplicate acknowledge.

Source files
------------

// File: rtl/fl_pkg.sv
// rtl/fl_pkg.sv - shared widths, defaults and state encoding for the flash word reader
package fl_pkg;

   localparam int FL_ADDR_W             = 23;
   localparam int FL_DQ_W               = 8;
   localparam int FL_DATA_W             = 2 * FL_DQ_W;
   localparam int FL_CNT_W              = 4;
   localparam int FL_ACCESS_CYCLES_DEF  = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      READ_LO = 2'd1,
      READ_HI = 2'd2
   } fl_state_e;

endpackage

// File: rtl/fl_word_reader.sv
// rtl/fl_word_reader.sv - reads one 16-bit word from an 8-bit parallel flash per toggle request
// Optional FL_BYTESWAP_EN: even byte lands in odata[15:8] instead of odata[7:0].
module fl_word_reader
   import fl_pkg::*;
#(
   parameter int ACCESS_CYCLES = FL_ACCESS_CYCLES_DEF
)
(
   input  logic                 iclk,
   input  logic                 ireset,
   input  logic [FL_ADDR_W-1:0] iaddr,
   input  logic                 ireq,
   output logic                 oack,
   output logic [FL_DATA_W-1:0] odata,
   output logic [FL_ADDR_W-1:0] ofl_addr,
   input  logic [FL_DQ_W-1:0]   ifl_dq,
   output logic                 ofl_ce_n,
   output logic                 ofl_oe_n,
   output logic                 ofl_we_n,
   output logic                 ofl_rst_n,
   output logic                 ofl_wp_n
);

   localparam logic [FL_CNT_W-1:0] CNT_LOAD = FL_CNT_W'(ACCESS_CYCLES - 1);

   fl_state_e               state_q, state_d;
   logic [FL_CNT_W-1:0]     cnt_q, cnt_d;
   logic [FL_ADDR_W-2:0]    waddr_q, waddr_d;
   logic [FL_DQ_W-1:0]      byte0_q, byte0_d;
   logic [FL_DATA_W-1:0]    odata_d;
   logic [FL_ADDR_W-1:0]    fl_addr_d;
   logic                    ack_d;
   logic                    ce_n_d;
   logic                    oe_n_d;
   logic                    unused_addr0;

   assign unused_addr0 = iaddr[0];

   // Read-only reader: write and write-protect lines are parked inactive.
   assign ofl_we_n = 1'b1;
   assign ofl_wp_n = 1'b1;

   always_ff @(posedge iclk) begin
      if (ireset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         waddr_q   <= '0;
         byte0_q   <= '0;
         odata     <= '0;
         oack      <= 1'b0;
         ofl_addr  <= '0;
         ofl_ce_n  <= 1'b1;
         ofl_oe_n  <= 1'b1;
         ofl_rst_n <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         waddr_q   <= waddr_d;
         byte0_q   <= byte0_d;
         odata     <= odata_d;
         oack      <= ack_d;
         ofl_addr  <= fl_addr_d;
         ofl_ce_n  <= ce_n_d;
         ofl_oe_n  <= oe_n_d;
         ofl_rst_n <= 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      waddr_d   = waddr_q;
      byte0_d   = byte0_q;
      odata_d   = odata;
      ack_d     = oack;
      fl_addr_d = ofl_addr;
      ce_n_d    = ofl_ce_n;
      oe_n_d    = ofl_oe_n;

      case (state_q)
         IDLE: begin
            // The flash is still in reset on the first edge after ireset drops.
            if (ofl_rst_n && (ireq != oack)) begin
               waddr_d   = iaddr[FL_ADDR_W-1:1];
               fl_addr_d = {iaddr[FL_ADDR_W-1:1], 1'b0};
               ce_n_d    = 1'b0;
               oe_n_d    = 1'b0;
               cnt_d     = CNT_LOAD;
               state_d   = READ_LO;
            end
         end

         READ_LO: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               byte0_d   = ifl_dq;
               fl_addr_d = {waddr_q, 1'b1};
               cnt_d     = CNT_LOAD;
               state_d   = READ_HI;
            end
         end

         READ_HI: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
`ifdef FL_BYTESWAP_EN
               odata_d = {byte0_q, ifl_dq};
`else
               odata_d = {ifl_dq, byte0_q};
`endif
               ack_d   = ~oack;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fl_word_reader.sv
// tb/tb_fl_word_reader.sv - directed bench for fl_word_reader (default, 1 and 15 access cycles)
module tb_fl_word_reader;

   logic        iclk = 1'b0;
   logic        ireset;
   logic        req [3];
   logic [22:0] ad  [3];
   logic        ack [3];
   logic [15:0] od  [3];
   logic [22:0] fa  [3];
   logic [7:0]  dq  [3];
   logic        ce  [3];
   logic        oe  [3];
   logic        we  [3];
   logic        rst [3];
   logic        wp  [3];

   int tests  = 0;
   int fails  = 0;
   int we_bad = 0;
   int ack_toggles = 0;
   logic ack0_prev = 1'b0;
   logic [15:0] last [3];

   always #5 iclk = ~iclk;

   // Flash model: byte at address a reads a[7:0] ^ 0x5A.
   assign dq[0] = fa[0][7:0] ^ 8'h5A;
   assign dq[1] = fa[1][7:0] ^ 8'h5A;
   assign dq[2] = fa[2][7:0] ^ 8'h5A;

   fl_word_reader u_def (
      .iclk(iclk), .ireset(ireset), .iaddr(ad[0]), .ireq(req[0]), .oack(ack[0]),
      .odata(od[0]), .ofl_addr(fa[0]), .ifl_dq(dq[0]), .ofl_ce_n(ce[0]), .ofl_oe_n(oe[0]),
      .ofl_we_n(we[0]), .ofl_rst_n(rst[0]), .ofl_wp_n(wp[0]));

   fl_word_reader #(.ACCESS_CYCLES(1)) u_ac1 (
      .iclk(iclk), .ireset(ireset), .iaddr(ad[1]), .ireq(req[1]), .oack(ack[1]),
      .odata(od[1]), .ofl_addr(fa[1]), .ifl_dq(dq[1]), .ofl_ce_n(ce[1]), .ofl_oe_n(oe[1]),
      .ofl_we_n(we[1]), .ofl_rst_n(rst[1]), .ofl_wp_n(wp[1]));

   fl_word_reader #(.ACCESS_CYCLES(15)) u_ac15 (
      .iclk(iclk), .ireset(ireset), .iaddr(ad[2]), .ireq(req[2]), .oack(ack[2]),
      .odata(od[2]), .ofl_addr(fa[2]), .ifl_dq(dq[2]), .ofl_ce_n(ce[2]), .ofl_oe_n(oe[2]),
      .ofl_we_n(we[2]), .ofl_rst_n(rst[2]), .ofl_wp_n(wp[2]));

   always @(negedge iclk) begin
      for (int i = 0; i < 3; i++)
         if (we[i] !== 1'b1 || wp[i] !== 1'b1) we_bad++;
      if (!ireset && ack[0] !== ack0_prev) ack_toggles++;
      ack0_prev <= ack[0];
   end

   typedef struct {
      logic [22:0] addr;
      logic [15:0] exp_le;
      logic [15:0] exp_be;
   } vec_t;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_word(input logic [22:0] a);
      logic [7:0] b0, b1;
      b0 = {a[7:1], 1'b0} ^ 8'h5A;
      b1 = {a[7:1], 1'b1} ^ 8'h5A;
`ifdef FL_BYTESWAP_EN
      return {b0, b1};
`else
      return {b1, b0};
`endif
   endfunction

   function automatic logic [15:0] pick(input vec_t v);
`ifdef FL_BYTESWAP_EN
      return v.exp_be;
`else
      return v.exp_le;
`endif
   endfunction

   task automatic run_req(input int i, input logic [22:0] a, input int ac, input logic [15:0] exp);
      int lat;
      logic [22:0] even;
      even = {a[22:1], 1'b0};
      lat = -1;
      req[i] = ~req[i];
      ad[i]  = a;
      for (int k = 1; k <= 4 * ac + 8; k++) begin
         @(posedge iclk); #1;
         if (k == 1) begin
            check("strobe_on", {ce[i], oe[i]}, 2'b00);
            check("addr_even_first", fa[i], even);
         end
         if (k == ac) check("addr_even_hold", fa[i], even);
         if (k == ac + 1) check("addr_odd", fa[i], even | 23'd1);
         if (k == 2 * ac) check("odata_held", od[i], last[i]);
         if (ack[i] == req[i]) begin
            lat = k - 1;
            break;
         end
      end
      check("latency", lat, 2 * ac);
      check("odata", od[i], exp);
      check("strobe_off", {ce[i], oe[i]}, 2'b11);
      check("addr_hold_idle", fa[i], even | 23'd1);
      last[i] = exp;
   endtask

   vec_t vecs [7];

   initial begin
      int k, first_k, second_k, t0;

      vecs[0] = '{23'h000100, 16'h5B5A, 16'h5A5B};
      vecs[1] = '{23'h000101, 16'h5B5A, 16'h5A5B};
      vecs[2] = '{23'h7FFFFE, 16'hA5A4, 16'hA4A5};
      vecs[3] = '{23'h123456, 16'h0D0C, 16'h0C0D};
      vecs[4] = '{23'h0000FE, 16'hA5A4, 16'hA4A5};
      vecs[5] = '{23'h555554, 16'h0F0E, 16'h0E0F};
      vecs[6] = '{23'h0000A4, 16'hFFFE, 16'hFEFF};

      ireset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req[i] = 1'b0; ad[i] = '0; last[i] = '0;
      end
      repeat (3) @(posedge iclk);
      #1;
      check("rst_oack", ack[0], 1'b0);
      check("rst_odata", od[0], 16'h0);
      check("rst_addr", fa[0], 23'h0);
      check("rst_strobes", {ce[0], oe[0]}, 2'b11);
      check("rst_fl_rst_n", {rst[0], rst[1], rst[2]}, 3'b000);

      // Request raised together with reset release: accepted one edge late.
      ireset = 1'b0;
      req[0] = 1'b1;
      ad[0]  = 23'h000100;
      first_k = -1;
      for (k = 1; k <= 40; k++) begin
         @(posedge iclk); #1;
         if (k == 1) begin
            check("fl_rst_n_release", rst[0], 1'b1);
            check("no_accept_first_edge", ce[0], 1'b1);
         end
         if (ack[0] == req[0]) begin first_k = k; break; end
      end
      check("post_reset_latency", first_k, 12);
      check("post_reset_odata", od[0], exp_word(23'h000100));
      last[0] = od[0];
      @(posedge iclk); #1;

      for (int v = 0; v < 7; v++) begin
         run_req(0, vecs[v].addr, 5, pick(vecs[v]));
         @(posedge iclk); #1;
      end

      run_req(1, 23'h123456, 1, exp_word(23'h123456));
      run_req(2, 23'h7FFFFE, 15, exp_word(23'h7FFFFE));

      // Re-request issued mid-transfer with a new address.
      @(posedge iclk); #1;
      req[0] = ~req[0];
      ad[0]  = 23'h000200;
      first_k = -1;
      second_k = -1;
      for (k = 1; k <= 60; k++) begin
         @(posedge iclk); #1;
         if (k == 3) begin
            req[0] = ~req[0];
            ad[0]  = 23'h7FFFFE;
         end
         if (first_k < 0 && ack[0] != ack0_prev && k > 3) begin
            first_k = k;
            check("retoggle_first_odata", od[0], exp_word(23'h000200));
         end
         if (first_k > 0 && k > first_k && ack[0] == req[0]) begin
            second_k = k;
            break;
         end
      end
      check("retoggle_first_k", first_k, 11);
      check("retoggle_second_k", second_k, 22);
      check("retoggle_second_odata", od[0], exp_word(23'h7FFFFE));
      last[0] = od[0];
      @(posedge iclk); #1;

      // Reset lands on edge 6 of a transfer.
      req[0] = ~req[0];
      ad[0]  = 23'h000300;
      repeat (5) @(posedge iclk);
      #1;
      ireset = 1'b1;
      for (int i = 0; i < 3; i++) req[i] = 1'b0;
      @(posedge iclk); #1;
      check("abort_oack", ack[0], 1'b0);
      check("abort_odata", od[0], 16'h0);
      check("abort_strobes", {ce[0], oe[0]}, 2'b11);
      check("abort_fl_rst_n", rst[0], 1'b0);
      ireset = 1'b0;
      for (int i = 0; i < 3; i++) last[i] = '0;
      @(posedge iclk); #1;
      t0 = ack_toggles;
      repeat (30) @(posedge iclk);
      #1;
      check("abort_no_toggle", ack_toggles - t0, 0);
      check("abort_idle_strobes", {ce[0], oe[0]}, 2'b11);

      t0 = ack_toggles;
      for (int n = 0; n < 1000; n++) begin
         run_req(0, 23'(2 * n), 5, exp_word(23'(2 * n)));
         @(posedge iclk); #1;
      end
      @(negedge iclk); #1;
      check("stream_ack_count", ack_toggles - t0, 1000);
      check("we_wp_high", we_bad, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
